// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM block: mode encoding and
// parameter defaults used by the top level and the frame counter.
package pwm_pkg;

  localparam int CH_DEFAULT    = 2;
  localparam int WIDTH_DEFAULT = 8;

  // Frame shape: edge-aligned counts 0..P, center-aligned counts 0..P..1.
  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } pwm_mode_e;

endpackage

// File: rtl/pwm_frame_ctr.sv
// Frame counter shared by all PWM channels. Produces the current count and
// a boundary flag; latches period and mode only at a frame boundary.
// A boundary is any enabled cycle whose count is 0: count 0 occurs exactly
// once per frame in both modes, and the counter sits at 0 while disabled
// or after reset, so the first enabled cycle is also a boundary.
module pwm_frame_ctr
  import pwm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             mode,
  input  logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] cnt,
  output logic             boundary
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             down_q;
  logic             down_d;
  logic [WIDTH-1:0] period_q;
  pwm_mode_e        mode_q;
  logic [WIDTH-1:0] period_eff;
  pwm_mode_e        mode_eff;

  assign boundary   = enable && (cnt_q == '0);
  // At a boundary the freshly presented period/mode already govern this frame.
  assign period_eff = boundary ? period : period_q;
  assign mode_eff   = boundary ? pwm_mode_e'(mode) : mode_q;
  assign cnt        = cnt_q;

  // Next-count and direction for the coming cycle.
  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    cnt_d  = cnt_q;
    down_d = down_q;
    if (mode_eff == MODE_EDGE) begin
      down_d = 1'b0;
      cnt_d  = (cnt_q >= period_eff) ? '0 : cnt_q + WIDTH'(1);
    end else if (!down_q || boundary) begin
      // Rising half: turn around at the top, or stay at 0 when P == 0.
      if (cnt_q >= period_eff) begin
        cnt_d  = (period_eff == '0) ? '0 : cnt_q - WIDTH'(1);
        down_d = (period_eff != '0);
      end else begin
        cnt_d  = cnt_q + WIDTH'(1);
        down_d = 1'b0;
      end
    end else begin
      // Falling half: reaching 0 lands on the next boundary.
      cnt_d  = cnt_q - WIDTH'(1);
      down_d = 1'b1;
    end
  end

  // Counter state and boundary latching of period/mode.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all registered state.
    if (rst) begin
      cnt_q    <= '0;
      down_q   <= 1'b0;
      period_q <= '0;
      mode_q   <= MODE_EDGE;
    end else if (!enable) begin
      cnt_q  <= '0;
      down_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      down_q <= down_d;
      if (boundary) begin
        period_q <= period;
        mode_q   <= pwm_mode_e'(mode);
      end
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with a one-deep pending sample buffer. New duty sets
// take effect at frame boundaries; a boundary with no pending set repeats
// the previous duties and reports an underrun.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int CH    = CH_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                mode,
  input  logic [WIDTH-1:0]    period,
  input  logic                sample_valid,
  input  logic [CH*WIDTH-1:0] sample_data,
  output logic                sample_ready,
  output logic [CH-1:0]       pwm_out,
  output logic                frame_start,
  output logic                underrun
);

  logic [WIDTH-1:0]    cnt;
  logic                boundary;
  logic [CH*WIDTH-1:0] pending_q;
  logic                pending_valid_q;
  logic [CH*WIDTH-1:0] active_q;
  logic [CH*WIDTH-1:0] duty_eff;
  logic                transfer;
  logic                take_pending;
  logic [CH-1:0]       hit;

  pwm_frame_ctr #(
    .WIDTH (WIDTH)
  ) u_frame_ctr (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .mode     (mode),
    .period   (period),
    .cnt      (cnt),
    .boundary (boundary)
  );

  assign sample_ready = !pending_valid_q;
  assign transfer     = sample_valid && sample_ready;
  assign take_pending = boundary && pending_valid_q;
  // Count 0 of a new frame already compares against the duty being loaded.
  assign duty_eff     = take_pending ? pending_q : active_q;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    assign hit[i] = cnt < duty_eff[i*WIDTH +: WIDTH];
  end

  // Pending buffer handshake and transfer into the active duty set.
  always_ff @(posedge clk) begin
    // NOTE: the sample registers are reset as well, so a reset never replays a stale duty set.
    if (rst) begin
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      active_q        <= '0;
    end else begin
      if (take_pending) begin
        pending_valid_q <= 1'b0;
        active_q        <= pending_q;
      end else if (transfer) begin
        pending_q       <= sample_data;
        pending_valid_q <= 1'b1;
      end
    end
  end

  // Registered outputs, one cycle behind the count they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out     <= '0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      pwm_out     <= enable ? hit : '0;
      frame_start <= boundary;
      underrun    <= boundary && !pending_valid_q;
    end
  end

endmodule

// File: doc/pwm_multi.md
PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 SHALL have parameter CH, default 2, number of PWM channels (1..8).
REQ-002 SHALL have parameter WIDTH, default 8, bits per sample and counter (4..16).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port enable  input  1  run; low holds the counter and forces outputs low.
REQ-006 SHALL have port mode  input  1  0 = edge-aligned, 1 = center-aligned; sampled at frame boundary.
REQ-007 SHALL have port period  input  WIDTH  top count; sampled at frame boundary.
REQ-008 SHALL have port sample_valid  input  1  producer offers a sample set.
REQ-009 SHALL have port sample_data  input  CH*WIDTH  channel i duty in bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port sample_ready  output  1  pending buffer empty; equals !pending_valid.
REQ-011 SHALL have port pwm_out  output  CH  registered PWM outputs.
REQ-012 SHALL have port frame_start  output  1  one-cycle pulse on the first count of each frame.
REQ-013 SHALL have port underrun  output  1  one-cycle pulse when a frame starts with no pending sample.

Function
REQ-014 SHALL accept a transfer on any cycle with sample_valid && sample_ready, storing sample_data into the pending buffer and setting pending_valid.
REQ-015 SHALL count edge-mode frames 0,1..P, where P is the latched period: frame length P+1.
REQ-016 SHALL count center-mode frames 0,1..P,P-1..1: frame length 2P, or 1 when P=0.
REQ-017 SHALL treat the cycle after the last count of a frame as a frame boundary. The first enabled cycle after rst or after enable low is also a boundary.
REQ-018 SHALL, at a boundary with pending_valid=1: copy pending to active duty, clear pending_valid, and latch mode and period.
REQ-019 SHALL, at a boundary with pending_valid=0: keep the previous active duty, latch mode and period, and pulse underrun.
REQ-020 SHALL, when a transfer and a boundary coincide with pending empty: pulse underrun, and load the transferred data into pending, not active.
REQ-021 SHALL drive pwm_out[i] in cycle k+1 as (cnt_k < active_i), using an unsigned WIDTH-bit compare: 1 cycle latency.
REQ-022 SHALL, in edge mode, give duty=0 zero high cycles per frame and duty>=P+1 all P+1 cycles high.
REQ-023 SHALL, in center mode, give duty d<=P exactly 2d-1 high cycles (0 if d=0), centered on count 0; d>P gives all cycles high.
REQ-024 SHALL register frame_start with the same 1-cycle latency as pwm_out, so it is high alongside the output of count 0.
REQ-025 SHALL, with enable low: hold cnt at 0, drive pwm_out=0, frame_start=0, underrun=0, and keep accepting into pending.
REQ-026 SHALL ignore period and mode changes made mid-frame until the next boundary.

Reset
REQ-027 SHALL, on rst high at a clock edge, clear cnt, active, pending, pending_valid, latched period and latched mode to 0, overriding any in-progress frame or transfer.
REQ-028 SHALL hold pwm_out=0, frame_start=0, underrun=0 and sample_ready=1 in the cycle after reset.

Structure
REQ-029 SHALL take the mode encoding constants (MODE_EDGE=0, MODE_CENTER=1) and the parameter defaults from shared package pwm_pkg.
REQ-030 SHALL place the up/down frame counter and boundary detection in one sub-module, pwm_frame_ctr, shared by all channels; compare logic is replicated per channel.

Verification
REQ-031 SHALL test: CH=2, WIDTH=8, edge, period=9, duties 3/0 -> ch0 high 3 of 10 cycles, ch1 never high, frame_start every 10 cycles.
REQ-032 SHALL test: center, period=4, duty=2 -> ch0 high 3 of 8 cycles (counts 1,0,1), frame length 8.
REQ-033 SHALL test: the producer stops after one sample set -> underrun pulses every following frame and the last duty repeats.
REQ-034 SHALL test: sample_valid held high -> one transfer per frame, sample_ready low from transfer until the next boundary, no data loss.
REQ-035 SHALL test: period changed 9->4 mid-frame -> current frame completes at 10 cycles, next frame 5 cycles; duty 255 -> always high.
REQ-036 SHALL test: rst asserted mid-frame with pending full -> next cycle outputs 0 and sample_ready=1; first enabled frame pulses underrun.
